// File: rtl/hazard_ctrl.sv
// Load-use and control hazard controller for the fetch/decode/execute front end.
// Drives PC/IF-ID enables, IF-ID flush and ID-EX bubble injection, plus a stall counter.
module hazard_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_r1Num,
    input  logic        id_r1Used,
    input  logic [2:0]  id_r2Num,
    input  logic        id_r2Used,
    input  logic        id_halt,
    input  logic        ex_memReadEnable,
    input  logic        ex_regWriteEnable,
    input  logic [2:0]  ex_regWriteNum,
    input  logic        ex_branchTaken,
    output logic        pcWriteEnable,
    output logic        ifidWriteEnable,
    output logic        ifidFlush,
    output logic        idexBubble,
    output logic [1:0]  state,
    output logic [15:0] perfStall
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] perf_q, perf_d;
    logic        hazard;
    logic        pc_wr, ifid_wr, ifid_flush, bubble;

    assign hazard = ex_memReadEnable & ex_regWriteEnable & id_valid &
                    ((id_r1Used & (id_r1Num == ex_regWriteNum)) |
                     (id_r2Used & (id_r2Num == ex_regWriteNum)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_wr      = 1'b0;
        ifid_wr    = 1'b0;
        ifid_flush = 1'b0;
        bubble     = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                // Branch wins: the decode instruction is squashed, so its hazard/halt is moot.
                if (ex_branchTaken) begin
                    pc_wr      = 1'b1;
                    ifid_wr    = 1'b1;
                    ifid_flush = 1'b1;
                    bubble     = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_INIT;
                    end
                end else if (hazard) begin
                    bubble = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_d = ST_STALL;
                        cnt_d   = STALL_INIT;
                    end
                end else if (id_halt && id_valid) begin
                    state_d = ST_HALT;
                end else begin
                    pc_wr   = 1'b1;
                    ifid_wr = 1'b1;
                end
            end
            ST_STALL: begin
                bubble = 1'b1;
                cnt_d  = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = ST_RUN;
            end
            ST_FLUSH: begin
                ifid_wr    = 1'b1;
                ifid_flush = 1'b1;
                bubble     = 1'b1;
                cnt_d      = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = ST_RUN;
            end
            default: begin
                bubble = 1'b1;
            end
        endcase

        perf_d = perf_q;
        if (!pc_wr && (state_q != ST_HALT) && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
            perf_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perf_q  <= perf_d;
        end
    end

    // Reset drives a safe NOP-everything pattern straight to the outputs in the same cycle.
    always_comb begin
        pcWriteEnable   = rst ? 1'b0  : pc_wr;
        ifidWriteEnable = rst ? 1'b0  : ifid_wr;
        ifidFlush       = rst ? 1'b1  : ifid_flush;
        idexBubble      = rst ? 1'b1  : bubble;
        state           = rst ? 2'b00 : state_q;
        perfStall       = rst ? 16'd0 : perf_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (STALL=1/FLUSH=2 and STALL=3/FLUSH=1)
// share stimulus; outputs are checked mid-cycle against hand-computed values.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_r1Used, id_r2Used, id_halt;
    logic [2:0]  id_r1Num, id_r2Num, ex_regWriteNum;
    logic        ex_memReadEnable, ex_regWriteEnable, ex_branchTaken;

    logic        a_pc, a_ifwr, a_ifflush, a_bub;
    logic [1:0]  a_state;
    logic [15:0] a_perf;
    logic        b_pc, b_ifwr, b_ifflush, b_bub;
    logic [1:0]  b_state;
    logic [15:0] b_perf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_r1Num(id_r1Num), .id_r1Used(id_r1Used),
        .id_r2Num(id_r2Num), .id_r2Used(id_r2Used), .id_halt(id_halt),
        .ex_memReadEnable(ex_memReadEnable), .ex_regWriteEnable(ex_regWriteEnable),
        .ex_regWriteNum(ex_regWriteNum), .ex_branchTaken(ex_branchTaken),
        .pcWriteEnable(a_pc), .ifidWriteEnable(a_ifwr), .ifidFlush(a_ifflush),
        .idexBubble(a_bub), .state(a_state), .perfStall(a_perf)
    );

    hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_r1Num(id_r1Num), .id_r1Used(id_r1Used),
        .id_r2Num(id_r2Num), .id_r2Used(id_r2Used), .id_halt(id_halt),
        .ex_memReadEnable(ex_memReadEnable), .ex_regWriteEnable(ex_regWriteEnable),
        .ex_regWriteNum(ex_regWriteNum), .ex_branchTaken(ex_branchTaken),
        .pcWriteEnable(b_pc), .ifidWriteEnable(b_ifwr), .ifidFlush(b_ifflush),
        .idexBubble(b_bub), .state(b_state), .perfStall(b_perf)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ctl = {pcWriteEnable, ifidWriteEnable, ifidFlush, idexBubble}
    task automatic expect_a(input string tag, input logic [3:0] ctl, input logic [1:0] st,
                            input logic [15:0] perf);
        check({"A ", tag, " ctl"},   16'({a_pc, a_ifwr, a_ifflush, a_bub}), 16'(ctl));
        check({"A ", tag, " state"}, 16'(a_state), 16'(st));
        check({"A ", tag, " perf"},  a_perf, perf);
    endtask

    task automatic expect_b(input string tag, input logic [3:0] ctl, input logic [1:0] st,
                            input logic [15:0] perf);
        check({"B ", tag, " ctl"},   16'({b_pc, b_ifwr, b_ifflush, b_bub}), 16'(ctl));
        check({"B ", tag, " state"}, 16'(b_state), 16'(st));
        check({"B ", tag, " perf"},  b_perf, perf);
    endtask

    task automatic idle();
        id_valid = 1'b0; id_r1Num = 3'd0; id_r1Used = 1'b0;
        id_r2Num = 3'd0; id_r2Used = 1'b0; id_halt = 1'b0;
        ex_memReadEnable = 1'b0; ex_regWriteEnable = 1'b0;
        ex_regWriteNum = 3'd0; ex_branchTaken = 1'b0;
    endtask

    // Load to r3 in execute, decode reads r3 through r2.
    task automatic load_use_r3();
        idle();
        id_valid = 1'b1; id_r1Num = 3'd0; id_r1Used = 1'b1;
        id_r2Num = 3'd3; id_r2Used = 1'b1;
        ex_memReadEnable = 1'b1; ex_regWriteEnable = 1'b1; ex_regWriteNum = 3'd3;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        settle();
        expect_a("reset", 4'b0011, 2'b00, 16'd0);
        expect_b("reset", 4'b0011, 2'b00, 16'd0);
        next_cycle();

        rst = 1'b0;
        settle();
        expect_a("idle", 4'b1100, 2'b00, 16'd0);
        expect_b("idle", 4'b1100, 2'b00, 16'd0);
        next_cycle();

        load_use_r3();
        settle();
        expect_a("hazard", 4'b0001, 2'b00, 16'd0);
        expect_b("hazard", 4'b0001, 2'b00, 16'd0);
        next_cycle();

        idle();
        settle();
        expect_a("post1", 4'b1100, 2'b00, 16'd1);
        expect_b("stall1", 4'b0001, 2'b01, 16'd1);
        next_cycle();

        settle();
        expect_a("post2", 4'b1100, 2'b00, 16'd1);
        expect_b("stall2", 4'b0001, 2'b01, 16'd2);
        next_cycle();

        settle();
        expect_a("post3", 4'b1100, 2'b00, 16'd1);
        expect_b("resume", 4'b1100, 2'b00, 16'd3);
        next_cycle();

        // r5 load but decode's r1 unused
        idle();
        id_valid = 1'b1; id_r1Num = 3'd5; id_r1Used = 1'b0; id_r2Num = 3'd2; id_r2Used = 1'b1;
        ex_memReadEnable = 1'b1; ex_regWriteEnable = 1'b1; ex_regWriteNum = 3'd5;
        settle();
        expect_a("r1unused", 4'b1100, 2'b00, 16'd1);
        expect_b("r1unused", 4'b1100, 2'b00, 16'd3);
        next_cycle();

        // r5 match but execute is not a load
        id_r1Used = 1'b1; ex_memReadEnable = 1'b0;
        settle();
        expect_a("noload", 4'b1100, 2'b00, 16'd1);
        expect_b("noload", 4'b1100, 2'b00, 16'd3);
        next_cycle();

        // r5 load match but decode slot invalid
        ex_memReadEnable = 1'b1; id_valid = 1'b0;
        settle();
        expect_a("invalid", 4'b1100, 2'b00, 16'd1);
        expect_b("invalid", 4'b1100, 2'b00, 16'd3);
        next_cycle();

        // r0 is an ordinary register for hazard purposes
        idle();
        id_valid = 1'b1; id_r1Num = 3'd0; id_r1Used = 1'b1; id_r2Num = 3'd6; id_r2Used = 1'b0;
        ex_memReadEnable = 1'b1; ex_regWriteEnable = 1'b1; ex_regWriteNum = 3'd0;
        settle();
        expect_a("r0haz", 4'b0001, 2'b00, 16'd1);
        expect_b("r0haz", 4'b0001, 2'b00, 16'd3);
        next_cycle();

        // reset lands on cycle 2 of B's 3-cycle stall
        idle();
        rst = 1'b1;
        settle();
        expect_a("midrst", 4'b0011, 2'b00, 16'd0);
        expect_b("midrst", 4'b0011, 2'b00, 16'd0);
        next_cycle();

        rst = 1'b0;
        settle();
        expect_a("afterrst", 4'b1100, 2'b00, 16'd0);
        expect_b("afterrst", 4'b1100, 2'b00, 16'd0);
        next_cycle();

        // taken branch with simultaneous hazard
        load_use_r3();
        ex_branchTaken = 1'b1;
        settle();
        expect_a("branch", 4'b1111, 2'b00, 16'd0);
        expect_b("branch", 4'b1111, 2'b00, 16'd0);
        next_cycle();

        idle();
        settle();
        expect_a("flush", 4'b0111, 2'b10, 16'd0);
        expect_b("noflush", 4'b1100, 2'b00, 16'd0);
        next_cycle();

        settle();
        expect_a("postflush", 4'b1100, 2'b00, 16'd1);
        expect_b("postflush", 4'b1100, 2'b00, 16'd0);
        next_cycle();

        idle();
        id_valid = 1'b1; id_halt = 1'b1;
        settle();
        expect_a("halt", 4'b0000, 2'b00, 16'd1);
        expect_b("halt", 4'b0000, 2'b00, 16'd0);
        next_cycle();

        idle();
        ex_branchTaken = 1'b1;
        settle();
        expect_a("halted_br", 4'b0001, 2'b11, 16'd2);
        expect_b("halted_br", 4'b0001, 2'b11, 16'd1);
        next_cycle();

        load_use_r3();
        ex_branchTaken = 1'b1;
        settle();
        expect_a("halted_haz", 4'b0001, 2'b11, 16'd2);
        expect_b("halted_haz", 4'b0001, 2'b11, 16'd1);
        next_cycle();

        idle();
        settle();
        expect_a("halted_idle", 4'b0001, 2'b11, 16'd2);
        expect_b("halted_idle", 4'b0001, 2'b11, 16'd1);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
